// File: rtl/m92_pkg.sv
// Shared types and constants for the M92 sprite path: the packed object layout
// seen by GA22, the DMA state encoding and small field helpers.
package m92_pkg;

  // Bit offsets of the four sprite RAM words inside a packed object.
  localparam int WORD0_LSB = 0;
  localparam int WORD1_LSB = 16;
  localparam int WORD2_LSB = 32;
  localparam int WORD3_LSB = 48;
  localparam int X_MSB     = 57;

  typedef struct packed {
    logic [5:0]  pad3;
    logic [9:0]  x;
    logic [5:0]  pad2;
    logic        flipy;
    logic        flipx;
    logic        pri;
    logic [6:0]  color;
    logic [15:0] code;
    logic [2:0]  layer;
    logic [1:0]  width;
    logic [1:0]  height;
    logic [8:0]  y;
  } obj_t;

  // Parked at x=0x3C0, which lies outside the visible linebuffer window.
  localparam obj_t OBJ_NULL = obj_t'({6'd0, 10'h3C0, 48'd0});

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_WR,
    S_NEXT
  } dma_state_t;

  function automatic obj_t pack_obj(input logic [15:0] w0, input logic [15:0] w1,
                                    input logic [15:0] w2, input logic [15:0] w3);
    logic [63:0] raw;
    raw = '0;
    raw[WORD1_LSB-1:WORD0_LSB] = w0;
    raw[WORD2_LSB-1:WORD1_LSB] = w1;
    raw[WORD3_LSB-1:WORD2_LSB] = w2;
    raw[X_MSB:WORD3_LSB]       = w3[X_MSB-WORD3_LSB:0];
    return obj_t'(raw);
  endfunction

  // Last span index of an object: 1, 2, 4 or 8 spans wide.
  function automatic logic [2:0] end_span_of(input logic [1:0] width);
    logic [3:0] spans;
    spans = 4'd1 << width;
    return 3'(spans - 4'd1);
  endfunction

endpackage

// File: rtl/sprite_list_buffer_if.sv
// CPU-side bus of the sprite list buffer: sprite RAM access plus DMA control.
interface sprite_list_buffer_if;
  logic [9:0]  cpu_addr;
  logic [15:0] cpu_din;
  logic        cpu_we;
  logic [15:0] cpu_dout;
  logic [8:0]  list_len;
  logic        dma_start;
  logic        dma_busy;

  modport master (
    output cpu_addr, cpu_din, cpu_we, list_len, dma_start,
    input  cpu_dout, dma_busy
  );

  modport slave (
    input  cpu_addr, cpu_din, cpu_we, list_len, dma_start,
    output cpu_dout, dma_busy
  );
endinterface

// File: rtl/dualport_ram.sv
// True dual-port RAM, one clock, registered read on both ports (read-first).
module dualport_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] din_a,
  output logic [WIDTH-1:0] dout_a,
  input  logic             we_b,
  input  logic [AW-1:0]    addr_b,
  input  logic [WIDTH-1:0] din_b,
  output logic [WIDTH-1:0] dout_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; only the read registers do, so it still maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values, giving read-first behaviour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      dout_a <= mem[addr_a];
      dout_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/sprite_list_buffer.sv
// Sprite RAM owner and GA22 object feeder: DMA sorts active entries by layer into
// the back bank of a double-banked object buffer; the front bank streams per span.
module sprite_list_buffer
  import m92_pkg::*;
#(
  parameter int NUM_OBJ = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic                ce_pix,
  input  logic                hpulse,
  input  logic [9:0]          count,
  sprite_list_buffer_if.slave bus,
  output logic [63:0]         obj_out
);

  localparam int IW = $clog2(NUM_OBJ);
  localparam logic [IW:0]   NUM_OBJ_W = (IW+1)'(NUM_OBJ);
  localparam logic [IW:0]   ONE_W     = {{IW{1'b0}}, 1'b1};
  localparam logic [IW-1:0] ONE_E     = {{(IW-1){1'b0}}, 1'b1};

  dma_state_t    state, state_nxt;
  logic          dma_go, obj_we, next_entry, next_layer, dma_done;
  logic [1:0]    rd_sel;
  logic [2:0]    layer;
  logic [IW-1:0] entry;
  logic [IW:0]   entry_p1, wptr, len_q, len_clamped;
  logic [47:0]   asm_q;
  logic [15:0]   spr_dout;
  obj_t          wr_obj;

  logic          front, swap_pending, line_start, swap_now, slot;
  logic [1:0][IW:0] fill;
  logic [IW:0]   front_fill, idx;
  logic [2:0]    span, end_span;
  logic [63:0]   obj_dout, obj_dout_unused;
  obj_t          next_obj, obj_q;
  logic          count_hi_unused;

  assign count_hi_unused = ^count[9:2];

  // ---------------------------------------------------------------- sprite RAM
  dualport_ram #(.WIDTH(16), .DEPTH(4*NUM_OBJ)) u_sprite_ram (
    .clk    (clk),
    .reset_n(reset_n),
    .we_a   (bus.cpu_we),
    .addr_a (bus.cpu_addr),
    .din_a  (bus.cpu_din),
    .dout_a (bus.cpu_dout),
    .we_b   (1'b0),
    .addr_b ({entry, rd_sel}),
    .din_b  (16'h0000),
    .dout_b (spr_dout)
  );

  // --------------------------------------------------------------- DMA engine
  assign len_clamped  = (bus.list_len > NUM_OBJ_W) ? NUM_OBJ_W : bus.list_len;
  assign entry_p1     = {1'b0, entry} + ONE_W;
  // Word 3 is still on the RAM output during WR, so the entry is assembled here.
  assign wr_obj       = pack_obj(asm_q[15:0], asm_q[31:16], asm_q[47:32], spr_dout);
  assign bus.dma_busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    dma_go     = 1'b0;
    obj_we     = 1'b0;
    next_entry = 1'b0;
    next_layer = 1'b0;
    dma_done   = 1'b0;
    rd_sel     = 2'd0;
    unique case (state)
      S_IDLE: if (bus.dma_start) begin
        dma_go    = 1'b1;
        state_nxt = S_RD0;
      end
      S_RD0: begin rd_sel = 2'd0; state_nxt = S_RD1; end
      S_RD1: begin rd_sel = 2'd1; state_nxt = S_RD2; end
      S_RD2: begin rd_sel = 2'd2; state_nxt = S_RD3; end
      S_RD3: begin rd_sel = 2'd3; state_nxt = S_WR;  end
      S_WR: begin
        obj_we    = (wr_obj.layer == layer) && (wptr < NUM_OBJ_W) && ({1'b0, entry} < len_q);
        state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (entry_p1 < len_q) begin
          next_entry = 1'b1;
          state_nxt  = S_RD0;
        end else if (layer != 3'd7) begin
          next_layer = 1'b1;
          state_nxt  = S_RD0;
        end else begin
          dma_done   = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      layer <= '0;
      entry <= '0;
      wptr  <= '0;
      len_q <= '0;
      asm_q <= '0;
    end else begin
      if (dma_go) begin
        layer <= '0;
        entry <= '0;
        wptr  <= '0;
        len_q <= len_clamped;
      end
      if (state == S_RD1) asm_q[15:0]  <= spr_dout;
      if (state == S_RD2) asm_q[31:16] <= spr_dout;
      if (state == S_RD3) asm_q[47:32] <= spr_dout;
      if (obj_we)         wptr <= wptr + ONE_W;
      if (next_entry)     entry <= entry + ONE_E;
      if (next_layer) begin
        layer <= layer + 3'd1;
        entry <= '0;
      end
    end
  end

  // ------------------------------------------------------------ object buffer
  dualport_ram #(.WIDTH(64), .DEPTH(2*NUM_OBJ)) u_obj_ram (
    .clk    (clk),
    .reset_n(reset_n),
    .we_a   (obj_we),
    .addr_a ({~front, wptr[IW-1:0]}),
    .din_a  (wr_obj),
    .dout_a (obj_dout_unused),
    .we_b   (1'b0),
    .addr_b ({front, idx[IW-1:0]}),
    .din_b  (64'd0),
    .dout_b (obj_dout)
  );

  // ------------------------------------------------------------- bank control
  assign line_start = hpulse & ce & ce_pix;
  assign swap_now   = line_start & swap_pending;

  // A completion coinciding with a swap already lands in the new front bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front        <= 1'b0;
      swap_pending <= 1'b0;
      fill         <= '0;
    end else begin
      if (swap_now)      front <= ~front;
      if (swap_now)      swap_pending <= 1'b0;
      else if (dma_done) swap_pending <= 1'b1;
      if (dma_done)      fill[~front] <= wptr;
    end
  end

  // ------------------------------------------------------------------- feeder
  assign slot       = ce && (count[1:0] == 2'b00);
  assign front_fill = fill[front];
  assign next_obj   = (idx >= front_fill) ? OBJ_NULL : obj_t'(obj_dout);
  assign obj_out    = obj_q;

  // Same span counter as GA22, so obj_q moves on the very edge GA22 latches it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= '0;
      span     <= '0;
      end_span <= '0;
      obj_q    <= OBJ_NULL;
    end else if (line_start) begin
      idx      <= '0;
      span     <= '0;
      end_span <= '0;
    end else if (slot) begin
      if (span == end_span) begin
        obj_q    <= next_obj;
        end_span <= end_span_of(next_obj.width);
        span     <= '0;
        if (idx != NUM_OBJ_W) idx <= idx + ONE_W;
      end else begin
        span <= span + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_list_buffer.sv
// Directed bench for sprite_list_buffer: DMA sorting and timing, span-paced feeding,
// bank isolation, empty and full lists, and asynchronous reset mid-DMA.
module tb_sprite_list_buffer;

  localparam logic [63:0] NULL_OBJ = 64'h03C0_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic        ce_pix = 1'b0;
  logic        hpulse = 1'b0;
  logic [9:0]  count = 10'd0;
  logic [63:0] obj_out;

  sprite_list_buffer_if bus ();

  sprite_list_buffer #(.NUM_OBJ(256)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .ce     (ce),
    .ce_pix (ce_pix),
    .hpulse (hpulse),
    .count  (count),
    .bus    (bus),
    .obj_out(obj_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] seen [1040];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input logic [15:0] w0, input logic [15:0] w1,
                                     input logic [15:0] w2, input logic [15:0] w3);
    return {6'd0, w3[9:0], w2, w1, w0};
  endfunction

  task automatic cpu_write(input logic [9:0] a, input logic [15:0] d);
    bus.cpu_addr = a;
    bus.cpu_din  = d;
    bus.cpu_we   = 1'b1;
    step;
    bus.cpu_we   = 1'b0;
  endtask

  task automatic write_entry(input int e, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
    cpu_write(10'(e*4 + 0), w0);
    cpu_write(10'(e*4 + 1), w1);
    cpu_write(10'(e*4 + 2), w2);
    cpu_write(10'(e*4 + 3), w3);
  endtask

  // Pulses dma_start, re-pulses it while busy (must be ignored), counts busy clocks.
  task automatic run_dma(input string tag, input int exp_clks);
    int n;
    bus.dma_start = 1'b1;
    step;
    n = 0;
    while (bus.dma_busy === 1'b1 && n < 20000) begin
      n++;
      bus.dma_start = (n == 5);
      step;
    end
    bus.dma_start = 1'b0;
    check(tag, 64'(n), 64'(exp_clks));
  endtask

  // One scanline: qualified hpulse, then n_ce ce clocks two clks apart, count stepping by one.
  task automatic run_line(input int n_ce, input int dma_at);
    count  = 10'h3FF;
    hpulse = 1'b1; ce = 1'b1; ce_pix = 1'b1;
    step;
    hpulse = 1'b0; ce = 1'b0; ce_pix = 1'b0;
    step;
    for (int c = 0; c < n_ce; c++) begin
      count         = c[9:0];
      ce            = 1'b1;
      ce_pix        = c[0];
      bus.dma_start = (c == dma_at);
      step;
      seen[c]       = obj_out;
      ce            = 1'b0;
      bus.dma_start = 1'b0;
      step;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got no summary expected summary");
    $fatal(1);
  end

  initial begin
    logic [63:0] a_obj, b_obj, exp;
    bus.cpu_addr  = '0;
    bus.cpu_din   = '0;
    bus.cpu_we    = 1'b0;
    bus.list_len  = '0;
    bus.dma_start = 1'b0;

    // Reset state
    repeat (3) step;
    check("rst_busy", 64'(bus.dma_busy), 64'd0);
    check("rst_obj", obj_out, NULL_OBJ);
    check("rst_dout", 64'(bus.cpu_dout), 64'd0);
    reset_n = 1'b1;
    step;

    // CPU port, one-clock read latency
    cpu_write(10'h000, 16'h1234);
    cpu_write(10'h3FF, 16'hBEEF);
    bus.cpu_addr = 10'h000; step;
    check("cpu_rd0", 64'(bus.cpu_dout), 64'h1234);
    bus.cpu_addr = 10'h3FF; step;
    check("cpu_rd1", 64'(bus.cpu_dout), 64'hBEEF);

    // Layer sort: entries on layers 2, 0, 1
    write_entry(0, 16'h4011, 16'h1111, 16'h0011, 16'h0100);
    write_entry(1, 16'h0022, 16'h2222, 16'h0022, 16'hFC22);
    write_entry(2, 16'h2033, 16'h3333, 16'h0233, 16'h0133);
    bus.list_len = 9'd3;
    run_dma("dmaA_clks", 144);
    check("dmaA_no_early", obj_out, NULL_OBJ);
    run_line(16, -1);
    check("sortA_0", seen[0], mk(16'h0022, 16'h2222, 16'h0022, 16'hFC22));
    check("sortA_hold", seen[3], mk(16'h0022, 16'h2222, 16'h0022, 16'hFC22));
    check("sortA_1", seen[4], mk(16'h2033, 16'h3333, 16'h0233, 16'h0133));
    check("sortA_2", seen[8], mk(16'h4011, 16'h1111, 16'h0011, 16'h0100));
    check("sortA_end", seen[12], NULL_OBJ);

    // Span pacing: width 2 (4 spans) then width 0
    a_obj = mk(16'h1044, 16'h4444, 16'h0044, 16'h0144);
    b_obj = mk(16'h0055, 16'h5555, 16'h01D5, 16'h0255);
    write_entry(0, 16'h1044, 16'h4444, 16'h0044, 16'h0144);
    write_entry(1, 16'h0055, 16'h5555, 16'h01D5, 16'h0255);
    bus.list_len = 9'd2;
    run_dma("dmaB_clks", 96);
    run_line(32, -1);
    for (int c = 0; c < 32; c++) begin
      exp = (c < 16) ? a_obj : (c < 20) ? b_obj : NULL_OBJ;
      check($sformatf("spanB_c%0d", c), seen[c], exp);
    end

    // DMA during active display: old bank keeps streaming for the whole line
    write_entry(0, 16'h0066, 16'h6666, 16'h0066, 16'h0166);
    bus.list_len = 9'd1;
    run_line(32, 2);
    for (int c = 0; c < 32; c += 4) begin
      exp = (c < 16) ? a_obj : (c < 20) ? b_obj : NULL_OBJ;
      check($sformatf("oldC_c%0d", c), seen[c], exp);
    end
    check("busyC_done", 64'(bus.dma_busy), 64'd0);
    run_line(8, -1);
    check("newC_0", seen[0], mk(16'h0066, 16'h6666, 16'h0066, 16'h0166));
    check("newC_end", seen[4], NULL_OBJ);

    // Empty list
    bus.list_len = 9'd0;
    run_dma("dmaD_clks", 48);
    run_line(8, -1);
    check("emptyD_0", seen[0], NULL_OBJ);
    check("emptyD_1", seen[4], NULL_OBJ);

    // Full list, all layer 7, list_len above capacity
    for (int i = 0; i < 256; i++)
      write_entry(i, 16'hE000 | 16'(i), 16'hC000 | 16'(i), 16'h0000, 16'(i));
    bus.list_len = 9'd300;
    run_dma("dmaE_clks", 12288);
    run_line(1032, -1);
    for (int s = 0; s < 258; s++) begin
      exp = (s < 256) ? mk(16'hE000 | 16'(s), 16'hC000 | 16'(s), 16'h0000, 16'(s)) : NULL_OBJ;
      check($sformatf("fullE_s%0d", s), seen[4*s], exp);
    end

    // Reset mid-DMA
    run_line(1, -1);
    check("preF_obj", seen[0], mk(16'hE000, 16'hC000, 16'h0000, 16'h0000));
    bus.list_len  = 9'd2;
    bus.dma_start = 1'b1;
    step;
    bus.dma_start = 1'b0;
    repeat (10) step;
    check("busyF_mid", 64'(bus.dma_busy), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstF_busy", 64'(bus.dma_busy), 64'd0);
    check("rstF_obj", obj_out, NULL_OBJ);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step;
    check("rstF_busy2", 64'(bus.dma_busy), 64'd0);
    run_line(8, -1);
    check("noswapF_0", seen[0], NULL_OBJ);
    check("noswapF_1", seen[4], NULL_OBJ);
    bus.list_len = 9'd1;
    run_dma("dmaF_clks", 48);
    run_line(4, -1);
    check("recoverF", seen[0], mk(16'hE000, 16'hC000, 16'h0000, 16'h0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
